// File: rtl/lc4_insn_encoder.sv
// LC4 instruction encoder: packs decoded fields into 20-bit words and streams
// them through a 2-entry buffer to instruction memory at an auto-incrementing address.
module lc4_insn_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [14:0]       in_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [19:0]       mem_wdata,
  output logic              illegal,
  output logic [7:0]        illegal_cnt,
  output logic              addr_wrap
);

  logic [19:0]       word;
  logic              is_ill;
  logic              push, pop, ill_acc;

  logic [1:0]        cnt_q, cnt_d;
  logic [19:0]       s0_q, s0_d, s1_q, s1_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              wrap_q, wrap_d;
  logic              ill_q, ill_d;
  logic [7:0]        icnt_q, icnt_d;

  always_comb begin
    word   = '0;
    is_ill = 1'b0;
    case (in_opcode)
      5'h05, 5'h06, 5'h0C, 5'h0D, 5'h0E, 5'h0F: word = {in_opcode, in_rd, in_rs, in_rt};
      5'h07, 5'h09:                             word = {in_opcode, in_rd, in_rs, in_imm[4:0]};
      5'h10:                                    word = {in_opcode, 5'b0, in_rs, 5'b0};
      5'h0B:                                    word = {in_opcode, in_rd, in_imm[9:0]};
      5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08: word = {in_opcode, in_imm};
      5'h0A:                                    word = {in_opcode, 15'b0};
      default:                                  is_ill = 1'b1;
    endcase
  end

  assign in_ready  = (cnt_q != 2'd2);
  assign mem_we    = (cnt_q != 2'd0);
  assign mem_wdata = s0_q;
  assign mem_addr  = wptr_q;
  assign illegal   = ill_q;
  assign illegal_cnt = icnt_q;
  assign addr_wrap = wrap_q;

  assign push    = in_valid && in_ready && !is_ill;
  assign ill_acc = in_valid && in_ready && is_ill;
  assign pop     = mem_we && mem_ready;

  // s0 is always the head; a pop shifts s1 forward.
  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) s0_d = word;
        else               s1_d = word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        s0_d  = s1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: s0_d = word; // only reachable with one entry
      default: ;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    wrap_d = wrap_q;
    if (base_load) begin
      wptr_d = base_addr;
      wrap_d = 1'b0;
    end else if (pop) begin
      wptr_d = wptr_q + ADDR_W'(1);
      if (&wptr_q) wrap_d = 1'b1;
    end
  end

  always_comb begin
    ill_d  = ill_acc;
    icnt_d = icnt_q;
    if (ill_acc && icnt_q != 8'hFF) icnt_d = icnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      wptr_q <= '0;
      wrap_q <= 1'b0;
      ill_q  <= 1'b0;
      icnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      wptr_q <= wptr_d;
      wrap_q <= wrap_d;
      ill_q  <= ill_d;
      icnt_q <= icnt_d;
    end
  end

endmodule
